// File: rtl/bp_me_pkg.sv
// Shared memory-end helpers: cache packet width and requester-ID width.
// Imported by the cache arbiter and its ID FIFO.
package bp_me_pkg;

  localparam int bsg_cache_opcode_width_gp = 6;
  localparam int paddr_width_dflt_gp = 40;

  // Matches the bsg_cache packet layout: opcode + addr + data + byte mask.
  function automatic int cache_pkt_width(int paddr_w, int dword_w);
    return bsg_cache_opcode_width_gp + paddr_w + dword_w + dword_w / 8;
  endfunction

  // Width of a requester index or lock holder, never below 1.
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_me_cache_id_fifo.sv
// Requester-ID FIFO: two pointers with wrap bits, full/empty from pointers.
// Ports: clk_i, reset_i, data_i/enq_i/full_o in, data_o/v_o/deq_i out.
module bp_me_cache_id_fifo
  import bp_me_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               enq_i,
  output logic               full_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               deq_i
);

  localparam int aw = id_width(els_p);

  // Pointer layout: {wrap, index}
  logic [aw:0]        wr_r;
  logic [aw:0]        rd_r;
  logic [width_p-1:0] mem [els_p];

  function automatic logic [aw:0] bump(logic [aw:0] p);
    if (p[aw-1:0] == aw'(els_p - 1))
      return {~p[aw], {aw{1'b0}}};
    else
      return {p[aw], p[aw-1:0] + 1'b1};
  endfunction

  logic same_idx;
  assign same_idx = (wr_r[aw-1:0] == rd_r[aw-1:0]);
  assign full_o = same_idx & (wr_r[aw] != rd_r[aw]);
  assign v_o = ~(same_idx & (wr_r[aw] == rd_r[aw]));
  assign data_o = mem[rd_r[aw-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_r <= '0;
      rd_r <= '0;
      for (int i = 0; i < els_p; i++)
        mem[i] <= '0;
    end else begin
      if (enq_i) begin
        mem[wr_r[aw-1:0]] <= data_i;
        wr_r <= bump(wr_r);
      end
      if (deq_i)
        rd_r <= bump(rd_r);
    end
  end

endmodule

// File: rtl/bp_me_cache_arbiter.sv
// Round-robin arbiter sharing one cache packet port among requesters,
// with burst lock and in-order response steering via an ID FIFO.
module bp_me_cache_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int paddr_width_p = paddr_width_dflt_gp,
  parameter int dword_width_p = 64,
  parameter int id_fifo_els_p = 4,
  parameter int pkt_width_lp = cache_pkt_width(paddr_width_p, dword_width_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]              req_pkt_v_i,
  input  logic [num_req_p-1:0]              req_pkt_lock_i,
  output logic [num_req_p-1:0]              req_pkt_ready_o,
  output logic [dword_width_p-1:0]          req_data_o,
  output logic [num_req_p-1:0]              req_v_o,
  input  logic [num_req_p-1:0]              req_yumi_i,
  output logic [pkt_width_lp-1:0]           cache_pkt_o,
  output logic                              cache_pkt_v_o,
  input  logic                              cache_pkt_ready_i,
  input  logic [dword_width_p-1:0]          cache_data_i,
  input  logic                              cache_v_i,
  output logic                              cache_yumi_o
);

  localparam int iw = id_width(num_req_p);
  localparam logic [num_req_p-1:0] one = num_req_p'(1);

  logic [iw-1:0]        last_r;
  logic [iw-1:0]        lock_id_r;
  logic                 lock_v_r;
  logic [num_req_p-1:0] elig;
  logic [iw-1:0]        grant;
  logic                 found;
  logic                 go;
  logic                 fifo_full;
  logic                 fifo_v;
  logic [iw-1:0]        head;

  // A held lock masks everyone but the holder.
  always_comb begin
    elig = req_pkt_v_i;
    if (lock_v_r)
      elig = req_pkt_v_i & (one << lock_id_r);
  end

  // Rotate to start after last_r, take first valid, map back.
  always_comb begin
    int idx;
    idx = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(last_r) + 1 + i;
      if (idx >= num_req_p)
        idx = idx - num_req_p;
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = iw'(idx);
      end
    end
  end

  assign go = found & cache_pkt_ready_i & ~fifo_full & ~reset_i;
  assign cache_pkt_v_o = go;

  always_comb begin
    cache_pkt_o = '0;
    if (found && !reset_i)
      cache_pkt_o = req_pkt_i[grant*pkt_width_lp +: pkt_width_lp];
  end

  always_comb begin
    req_pkt_ready_o = '0;
    if (go)
      req_pkt_ready_o = one << grant;
  end

  bp_me_cache_id_fifo #(
    .width_p(iw),
    .els_p  (id_fifo_els_p)
  ) id_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (grant),
    .enq_i  (go),
    .full_o (fifo_full),
    .data_o (head),
    .v_o    (fifo_v),
    .deq_i  (cache_yumi_o)
  );

  always_comb begin
    req_v_o = '0;
    if (cache_v_i && fifo_v)
      req_v_o = one << head;
  end

  assign cache_yumi_o = cache_v_i & fifo_v & req_yumi_i[head];
  assign req_data_o = reset_i ? '0 : cache_data_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_r <= iw'(num_req_p - 1);
      lock_v_r <= 1'b0;
      lock_id_r <= '0;
    end else if (go) begin
      last_r <= grant;
      lock_v_r <= req_pkt_lock_i[grant];
      lock_id_r <= grant;
    end
  end

  // A response with nothing outstanding means the cache broke protocol.
  assert property (@(posedge clk_i) disable iff (reset_i)
    !(cache_v_i && !fifo_v));

endmodule

// File: doc/bp_me_cache_arbiter.md
# bp_me_cache_arbiter

Shares one bsg_cache packet port between `num_req_p` CCE-to-cache converters (e.g. per-core or per-channel command streams) in the memory end. Arbitration is round-robin, and packets are forwarded with zero added latency. A per-requester lock holds the grant across a burst. The cache returns responses in order; a requester-ID FIFO steers each response back to the requester that issued the matching packet.

## Interface
- `num_req_p`, default 2: number of requesters; ≥2.
- `paddr_width_p`, default from `bp_params_p`: physical address width of cache packets.
- `dword_width_p`, default 64: cache data width.
- `id_fifo_els_p`, default 4: maximum outstanding cache packets.
- `pkt_width_lp`, derived: `` `bsg_cache_pkt_width(paddr_width_p, dword_width_p) ``.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_pkt_i`  in  `num_req_p*pkt_width_lp`  packet per requester; requester i occupies slice i.
- `req_pkt_v_i`  in  `num_req_p`  packet valid; held until accepted.
- `req_pkt_lock_i`  in  `num_req_p`  keep the grant after this packet.
- `req_pkt_ready_o`  out  `num_req_p`  packet accepted this cycle when ready&v.
- `req_data_o`  out  `dword_width_p`  response data, broadcast to all requesters.
- `req_v_o`  out  `num_req_p`  response valid, one-hot or zero.
- `req_yumi_i`  in  `num_req_p`  response consumed.
- `cache_pkt_o`  out  `pkt_width_lp`  packet to the cache.
- `cache_pkt_v_o`  out  1  packet valid (ready-then-valid).
- `cache_pkt_ready_i`  in  1  cache can accept a packet; must not depend on `cache_pkt_v_o`.
- `cache_data_i`  in  `dword_width_p`  cache response data.
- `cache_v_i`  in  1  cache response valid.
- `cache_yumi_o`  out  1  cache response consumed.

## Operation
- **State**
  - `last_r`: last granted index, `lg(num_req_p)` bits.
  - `lock_v_r`, `lock_id_r`: lock flag and lock holder.
  - ID FIFO of `id_fifo_els_p` entries.
- **Grant**
  - When `lock_v_r` is set, only `lock_id_r` may be granted; other requesters wait even if valid.
  - Otherwise, grant the first valid requester scanning from `last_r+1` modulo `num_req_p`.
- **Accept condition:** `go = (|eligible_v) & cache_pkt_ready_i & ~fifo_full`.
- **Accept outputs**
  - `cache_pkt_v_o = go`.
  - `cache_pkt_o` = granted slice; it is 0 when there is no grant.
  - `req_pkt_ready_o[g] = go`; every other bit is 0.
- **On accept**
  - Enqueue g into the ID FIFO.
  - `last_r <= g`.
  - `lock_v_r <= req_pkt_lock_i[g]`, `lock_id_r <= g`.
  - A lock is released only by an accepted packet from the holder that has lock=0.
- **Response routing**
  - h = FIFO head.
  - `req_v_o[h] = cache_v_i & fifo_v`.
  - `req_data_o = cache_data_i`.
  - `cache_yumi_o = cache_v_i & fifo_v & req_yumi_i[h]`; the FIFO dequeues on `cache_yumi_o`.
- Every accepted packet, including TAGST, TAGFL and stores, produces exactly one cache response.
- If `cache_v_i` is asserted while the FIFO is empty, it is a protocol error: assert it in simulation and do not yumi.

## Timing
- **Reset values (asynchronous)**
  - `last_r = num_req_p-1`, so requester 0 wins first.
  - `lock_v_r = 0`, `lock_id_r = 0`.
  - FIFO empty.
  - All outputs are 0 while in reset.
- Request → cache path is combinational, 0 cycles; one packet per cycle maximum.
- Cache → requester response path is combinational, 0 cycles; one response per cycle.
- **FIFO full:** no accept, even if a dequeue happens in the same cycle (an enqueue never depends on a dequeue). Throughput stays at 1/cycle whenever `id_fifo_els_p ≥ cache round-trip`.
- **FIFO empty:** `req_v_o = 0`. An enqueue and a response cannot overlap in the same cycle, because the cache has at least 1 cycle of latency.
- A requester dropping `req_pkt_v_i` while holding the lock stalls everyone; this is by design and the requester is responsible for it.
- Reset asserted mid-operation: outstanding IDs are discarded; the cache is reset on the same `reset_i`.
- `last_r` wraps modulo `num_req_p`; non-power-of-2 `num_req_p` is supported.

## Structure
- **Shared package (`bp_me_pkg`)**
  - Lock/ID width localparam helper.
  - Reuse `` `declare_bsg_cache_pkt_s `` from `bsg_cache_pkg`; add no new typedef.
- **Sub-module `bp_me_cache_id_fifo`:** small FIFO (two-pointer plus wrap bit), asynchronous reset, width `lg(num_req_p)`. Full/empty come from the pointers.
- The round-robin grant is inline combinational logic: a rotate, a priority encode, then a rotate back.

## Test plan
- **Reset values:** assert reset mid-burst → all outputs 0 immediately, and after release `last_r=1` (with `num_req_p=2`).
- **Alternation:** both requesters hold v, cache always ready → grants alternate 0,1,0,1; the ID FIFO holds 0,1; responses go out with `req_v_o` = 01, 10, 01, 10.
- **Lock:** req0 sends 8 LM packets with lock=1 on the first 7, while req1 holds v throughout → 8 consecutive grants to 0, then req1 is granted.
- **Back-pressure:** `id_fifo_els_p=4`, cache never responds → exactly 4 accepts, then `cache_pkt_v_o=0`; after one yumi, 1 more accept in the following cycle.
- **Head blocking:** response for req1 at the head with `req_yumi_i[1]=0` for 5 cycles → `cache_yumi_o=0` and data held, and `req_v_o[0]` stays 0.
- **Cache stall:** `cache_pkt_ready_i=0` → `cache_pkt_v_o=0`, all `req_pkt_ready_o=0`, `last_r` unchanged.
